// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the HD44780-style LCD sequencer
//
// Purpose: state encoding, init command list, clear/home codes and DDRAM
//          line base addresses used by lcd_sequencer.
// Ports:   none (package).

package lcd_pkg;

  typedef enum logic [3:0] {
    PWR_WAIT,
    INIT_SEND,
    INIT_WAIT,
    CLR_WAIT,
    IDLE,
    SEND,
    WAIT_DONE,
    WRAP_SEND,
    WRAP_WAIT
  } state_t;

  // Init list: function set, display on, entry mode, clear (in that order).
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;

  localparam logic [7:0] ADDR_LINE0   = 8'h80;
  localparam logic [7:0] ADDR_LINE1   = 8'hC0;

  localparam int INIT_LEN = 4;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = CMD_FUNC_SET;
      2'd1:    init_cmd = CMD_DISP_ON;
      2'd2:    init_cmd = CMD_ENTRY;
      default: init_cmd = CMD_CLEAR;
    endcase
  endfunction

  // Clear and home both need the long settle time on the panel.
  function automatic logic is_clr_home(input logic [7:0] cmd);
    is_clr_home = (cmd == CMD_CLEAR) || (cmd == CMD_HOME);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// rtl/lcd_delay_timer.sv - cycle delay timer shared by power-up and clear waits
//
// Purpose: counts cycles since the last load (or since reset); o_expired is
//          high in the i_len-th cycle of the window (i_len >= 1).
// Ports:   clk, rst      - clock, asynchronous active-high reset
//          i_load        - restart the window; next cycle is window cycle 1
//          i_len[17:0]   - window length in cycles
//          o_expired     - high during the last cycle of the window

module lcd_delay_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [17:0] i_len,
  output logic        o_expired
);

  logic [17:0] r_cnt;

  // Reset leaves the counter at 0 so the power-up window starts on release
  // without needing an explicit load. Saturates so it never re-fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 18'd1;
    end
  end

  assign o_expired = (r_cnt == (i_len - 18'd1));

endmodule

// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - LCD power-up/init sequencer with host write path and cursor tracking
//
// Purpose: waits PWRUP_CYC after reset, sends the init list, then accepts host
//          command/character bytes, forwarding each to a byte transmitter and
//          issuing a line-address command when a character fills a line.
// Ports:   clk, rst                 - clock, asynchronous active-high reset
//          wr_valid/wr_ready        - host request handshake
//          wr_cd, wr_data[7:0]      - host byte (0 = command, 1 = character)
//          tx_start                 - one-cycle start pulse to the transmitter
//          tx_data[7:0], tx_cd      - byte and flag, held until tx_done
//          tx_done                  - transmitter completion tick
//          init_done                - init sequence complete (sticky until reset)

module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC = 200000,
  parameter int CLR_CYC   = 20000,
  parameter int COLS      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_cd,
  input  logic [7:0] wr_data,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       tx_cd,
  input  logic       tx_done,
  output logic       init_done
);

  localparam int               CW          = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0]    LP_COL_LAST = CW'(COLS - 1);
  localparam logic [17:0]      LP_PWR_LEN  = 18'(PWRUP_CYC);
  localparam logic [17:0]      LP_CLR_LEN  = 18'(CLR_CYC);
  localparam logic [1:0]       LP_IDX_LAST = 2'(INIT_LEN - 1);

  state_t          r_state;
  logic [1:0]      r_idx;
  logic            r_tx_start;
  logic [7:0]      r_tx_data;
  logic            r_tx_cd;
  logic            r_wr_ready;
  logic            r_init_done;
  logic            r_line;
  logic [CW-1:0]   r_col;

  logic            w_expired;
  logic            w_clr_done;
  logic [17:0]     w_tmr_len;

  // A clear/home command finishing restarts the timer so that CLR_WAIT
  // begins at window cycle 1 on the very next edge.
  assign w_clr_done = tx_done && !r_tx_cd && is_clr_home(r_tx_data) &&
                      ((r_state == INIT_WAIT) || (r_state == WAIT_DONE));

  assign w_tmr_len  = (r_state == PWR_WAIT) ? LP_PWR_LEN : LP_CLR_LEN;

  lcd_delay_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_clr_done),
    .i_len     (w_tmr_len),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= PWR_WAIT;
      r_idx       <= '0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_tx_cd     <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_init_done <= 1'b0;
      r_line      <= 1'b0;
      r_col       <= '0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        PWR_WAIT: begin
          if (w_expired) begin
            r_tx_data  <= init_cmd(2'd0);
            r_tx_cd    <= 1'b0;
            r_tx_start <= 1'b1;
            r_state    <= INIT_SEND;
          end
        end

        INIT_SEND: r_state <= INIT_WAIT;

        INIT_WAIT: begin
          if (tx_done) begin
            // The list ends with a clear, so CLR_WAIT hands over to IDLE.
            if (w_clr_done) begin
              r_state <= CLR_WAIT;
            end else if (r_idx == LP_IDX_LAST) begin
              r_state     <= IDLE;
              r_wr_ready  <= 1'b1;
              r_init_done <= 1'b1;
            end else begin
              r_idx      <= r_idx + 2'd1;
              r_tx_data  <= init_cmd(r_idx + 2'd1);
              r_tx_start <= 1'b1;
              r_state    <= INIT_SEND;
            end
          end
        end

        CLR_WAIT: begin
          if (w_expired) begin
            r_state     <= IDLE;
            r_wr_ready  <= 1'b1;
            r_init_done <= 1'b1;
          end
        end

        IDLE: begin
          if (wr_valid && r_wr_ready) begin
            r_wr_ready <= 1'b0;
            r_tx_data  <= wr_data;
            r_tx_cd    <= wr_cd;
            r_tx_start <= 1'b1;
            r_state    <= SEND;
          end
        end

        SEND: r_state <= WAIT_DONE;

        WAIT_DONE: begin
          if (tx_done) begin
            if (r_tx_cd) begin
              if (r_col == LP_COL_LAST) begin
                // Line full: move to column 0 of the other line.
                r_col      <= '0;
                r_line     <= ~r_line;
                r_tx_data  <= r_line ? ADDR_LINE0 : ADDR_LINE1;
                r_tx_cd    <= 1'b0;
                r_tx_start <= 1'b1;
                r_state    <= WRAP_SEND;
              end else begin
                r_col      <= r_col + CW'(1);
                r_wr_ready <= 1'b1;
                r_state    <= IDLE;
              end
            end else if (w_clr_done) begin
              r_line  <= 1'b0;
              r_col   <= '0;
              r_state <= CLR_WAIT;
            end else begin
              // Set-DDRAM-address command: bit6 selects line, low nibble column.
              if (r_tx_data[7]) begin
                r_line <= r_tx_data[6];
                r_col  <= CW'(r_tx_data[3:0]);
              end
              r_wr_ready <= 1'b1;
              r_state    <= IDLE;
            end
          end
        end

        WRAP_SEND: r_state <= WRAP_WAIT;

        WRAP_WAIT: begin
          if (tx_done) begin
            r_wr_ready <= 1'b1;
            r_state    <= IDLE;
          end
        end

        default: r_state <= PWR_WAIT;
      endcase
    end
  end

  assign wr_ready  = r_wr_ready;
  assign tx_start  = r_tx_start;
  assign tx_data   = r_tx_data;
  assign tx_cd     = r_tx_cd;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb/tb_lcd_sequencer.sv - self-checking bench for lcd_sequencer

module tb_lcd_sequencer;
  import lcd_pkg::*;

  localparam int PWR   = 100;
  localparam int CLR   = 20;
  localparam int NCOL  = 16;
  localparam int TXLAT = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       wr_cd = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_cd;
  logic       tx_done = 1'b0;
  logic       init_done;

  int checks = 0;
  int errors = 0;
  int cyc;
  int first_start_cyc = -1;
  int done_cyc = -1;
  int inj_cyc = -1;
  int ready_cyc = 0;
  logic [8:0] sb[$];
  logic exp_line = 1'b0;
  int   exp_col = 0;

  lcd_sequencer #(.PWRUP_CYC(PWR), .CLR_CYC(CLR), .COLS(NCOL)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_cd     (wr_cd),
    .wr_data   (wr_data),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_cd     (tx_cd),
    .tx_done   (tx_done),
    .init_done (init_done)
  );

  always #50 clk = ~clk;

  // Cycle k is the cycle after the k-th rising edge following reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model + scoreboard consumer.
  task automatic monitor();
    logic [8:0] held;
    logic [8:0] e;
    int pend;
    logic prev_start;
    held = '0;
    pend = 0;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0;
        prev_start = 1'b0;
        tx_done = 1'b0;
      end else begin
        if (prev_start) chk("start_one_cycle", 32'(tx_start), 32'd0);
        tx_done = (inj_cyc == cyc);
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            tx_done = 1'b1;
            done_cyc = cyc;
            chk("tx_hold", 32'({tx_cd, tx_data}), 32'(held));
          end
        end
        if (tx_start) begin
          if (first_start_cyc < 0) first_start_cyc = cyc;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_unexpected_start: observed 0x%0h expected none", {tx_cd, tx_data});
          end else begin
            e = sb.pop_front();
            chk("tx_byte", 32'({tx_cd, tx_data}), 32'(e));
          end
          held = {tx_cd, tx_data};
          pend = TXLAT;
        end
        prev_start = tx_start;
      end
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (wr_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(wr_ready), 32'd1);
    ready_cyc = cyc;
  endtask

  task automatic push_init();
    sb.push_back({1'b0, 8'h38});
    sb.push_back({1'b0, 8'h0C});
    sb.push_back({1'b0, 8'h06});
    sb.push_back({1'b0, 8'h01});
  endtask

  task automatic host_write(input logic cd, input logic [7:0] d);
    wait_ready("pre_wr");
    wr_valid = 1'b1;
    wr_cd    = cd;
    wr_data  = d;
    sb.push_back({cd, d});
    if (cd) begin
      if (exp_col == NCOL - 1) begin
        exp_col  = 0;
        exp_line = ~exp_line;
        sb.push_back({1'b0, (exp_line ? 8'hC0 : 8'h80)});
      end else begin
        exp_col++;
      end
    end else if (d == 8'h01 || d == 8'h02) begin
      exp_line = 1'b0;
      exp_col  = 0;
    end else if (d[7]) begin
      exp_line = d[6];
      exp_col  = int'(d[3:0]);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    chk("start_after_accept", 32'(tx_start), 32'd1);
    chk("ready_low_busy", 32'(wr_ready), 32'd0);
    wait_ready("post_wr");
  endtask

  task automatic chk_cursor(input string tag);
    chk({tag, "_line"}, 32'(dut.r_line), 32'(exp_line));
    chk({tag, "_col"},  32'(dut.r_col),  32'(exp_col));
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_start",  32'(tx_start),  32'd0);
    chk("rst_tx_data",   32'(tx_data),   32'd0);
    chk("rst_tx_cd",     32'(tx_cd),     32'd0);
    chk("rst_wr_ready",  32'(wr_ready),  32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_state",     32'(dut.r_state), 32'(PWR_WAIT));

    // Power-up and init
    push_init();
    rst = 1'b0;
    wait_ready("init");
    chk("first_start_cyc", 32'(first_start_cyc), 32'(PWR));
    chk("init_clr_gap", 32'(ready_cyc - done_cyc), 32'(CLR + 1));
    chk("init_done", 32'(init_done), 32'd1);
    chk("init_sb_empty", 32'(sb.size()), 32'd0);
    chk_cursor("init");

    // Single character
    host_write(1'b1, 8'h41);
    chk("char_ready_gap", 32'(ready_cyc - done_cyc), 32'd1);
    chk_cursor("char41");

    // Line wrap both ways
    host_write(1'b0, 8'h80);
    chk_cursor("home_addr");
    for (int i = 0; i < NCOL; i++) host_write(1'b1, 8'h30 + 8'(i));
    chk_cursor("wrap1");
    chk("wrap1_sb_empty", 32'(sb.size()), 32'd0);
    for (int i = 0; i < NCOL; i++) host_write(1'b1, 8'h61 + 8'(i));
    chk_cursor("wrap0");
    chk("wrap0_sb_empty", 32'(sb.size()), 32'd0);

    // Host commands
    host_write(1'b0, 8'hC5);
    chk_cursor("addr_c5");
    chk("addr_ready_gap", 32'(ready_cyc - done_cyc), 32'd1);
    host_write(1'b0, 8'h0C);
    chk_cursor("plain_cmd");
    host_write(1'b0, 8'h01);
    chk("clear_gap", 32'(ready_cyc - done_cyc), 32'(CLR + 1));
    chk_cursor("clear");
    host_write(1'b0, 8'hC5);
    chk_cursor("addr_c5_b");
    host_write(1'b0, 8'h02);
    chk("home_gap", 32'(ready_cyc - done_cyc), 32'(CLR + 1));
    chk_cursor("home");

    // Reset while a character is in flight
    wait_ready("pre_rst");
    wr_valid = 1'b1;
    wr_cd    = 1'b1;
    wr_data  = 8'h5A;
    sb.push_back({1'b1, 8'h5A});
    @(negedge clk);
    wr_valid = 1'b0;
    chk("inflight_start", 32'(tx_start), 32'd1);
    repeat (2) @(negedge clk);
    chk("inflight_data", 32'({tx_cd, tx_data}), 32'h15A);
    #1 rst = 1'b1;
    #1;
    chk("arst_tx_start",  32'(tx_start),  32'd0);
    chk("arst_tx_data",   32'(tx_data),   32'd0);
    chk("arst_tx_cd",     32'(tx_cd),     32'd0);
    chk("arst_wr_ready",  32'(wr_ready),  32'd0);
    chk("arst_init_done", 32'(init_done), 32'd0);
    chk("arst_line",      32'(dut.r_line), 32'd0);
    chk("arst_col",       32'(dut.r_col),  32'd0);
    sb.delete();
    exp_line = 1'b0;
    exp_col  = 0;
    first_start_cyc = -1;
    inj_cyc = 50;
    // Request held across the whole init sequence.
    wr_valid = 1'b1;
    wr_cd    = 1'b1;
    wr_data  = 8'h42;
    repeat (3) @(negedge clk);
    push_init();
    rst = 1'b0;
    wait_ready("reinit");
    chk("reinit_first_start", 32'(first_start_cyc), 32'(PWR));
    chk("reinit_clr_gap", 32'(ready_cyc - done_cyc), 32'(CLR + 1));
    chk("reinit_done", 32'(init_done), 32'd1);
    sb.push_back({1'b1, 8'h42});
    exp_col = 1;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("held_req_start", 32'(tx_start), 32'd1);
    chk("held_req_start_cyc", 32'(cyc - ready_cyc), 32'd1);
    wait_ready("held_req");
    chk_cursor("held_req");
    repeat (10) @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    chk("final_init_done", 32'(init_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
